regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
- Writeback scheduler for the superscalar core's 4-read/2-write register file.
- Three writeback sources (ALU0 = src0, ALU1 = src1, MEM = src2) compete for the register file's two write ports.
- Grants up to two nonzero-destination writes per cycle using round-robin priority, and never issues two same-cycle writes to one register.
- Outputs are registered and connect directly to the register file's we1/we2, writeRegister1/2 and writeData1/2.

Parameters:
- DATA_W, 32, write data width.
- REG_W, 5, register index width.
- CNT_W, 16, width of the saturating conflict counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- hold  in  1  freeze; when 1, no requests are granted.
- src_valid  in  3  per-source write request; bit i = source i.
- src_reg  in  3*REG_W  destination register; source i occupies bits [i*REG_W +: REG_W].
- src_data  in  3*DATA_W  write data; source i occupies bits [i*DATA_W +: DATA_W].
- src_ready  out  3  combinational grant; a transfer occurs when valid & ready at the rising edge.
- we1  out  1  register-file write enable, port 1.
- writeRegister1  out  REG_W  port-1 destination.
- writeData1  out  DATA_W  port-1 data.
- we2  out  1  register-file write enable, port 2.
- writeRegister2  out  REG_W  port-2 destination.
- writeData2  out  DATA_W  port-2 data.
- conflict_cnt  out  CNT_W  saturating count of cycles in which a same-register collision deferred a request.

Behaviour:
- Reset (rst=0, asynchronous): rr_ptr=0; we1=we2=0; writeRegister1/2=0; writeData1/2=0; conflict_cnt=0.
- Reset applied mid-operation discards any in-flight write: we1/we2 drop immediately.
- State: rr_ptr (2 bits, values 0..2) selects the highest-priority source.
- Scan order each cycle: rr_ptr, rr_ptr+1, rr_ptr+2, all mod 3.
- Register r0 requests:
  - src_ready=1 whenever hold=0.
  - They consume no port and never assert a we.
  - They do not affect rr_ptr.
- Nonzero requests are visited in scan order:
  - Granted if a port is free and the destination differs from every destination already granted this cycle.
  - The first grant goes to port 1, the second to port 2.
  - A third valid nonzero request gets ready=0.
- Collision: a valid nonzero request whose destination matches an earlier grant this cycle gets ready=0, and conflict_cnt increments by 1 (once per cycle, saturating at all-ones).
- A collision-deferred request may be granted port 2 in a later cycle. No port is left unused when a non-conflicting request exists.
- Latency: a request accepted at edge N drives its port outputs from edge N onward, i.e. valid during cycle N+1.
- Port outputs hold the last value when their we is 0; data and register are not cleared.
- rr_ptr update: on any nonzero grant, rr_ptr becomes (index of the last granted source in scan order)+1 mod 3. Otherwise it is unchanged.
- Sources are never starved: any continuously valid request is granted within 3 cycles unless hold is asserted or it collides.
- hold=1:
  - All src_ready=0 (r0 requests included).
  - Next edge: we1=we2=0.
  - rr_ptr and conflict_cnt are unchanged.
- Sources must keep src_reg and src_data stable while valid is high and ready is low. The block does not check this.
- Requests with src_valid=0 are ignored regardless of reg/data.

Test Plan:
- Reset: assert rst=0 mid-stream with we1=1 → we1=we2=0, conflict_cnt=0 immediately; first post-reset grant order starts at src0.
- Three requests, src0 to r5 (0xAAAAAAAA), src1 to r10 (0x55555555), src2 to r7 (0x12345678), rr_ptr=0 → ready=3'b011; next cycle we1=1/r5/0xAAAAAAAA and we2=1/r10/0x55555555; rr_ptr=2. Following cycle (src2 still valid) → src2 granted on port 1, we2=0.
- Collision: src0 and src2 both target r9, src1 idle → only the source first in scan order is ready; conflict_cnt=1; the other is granted the next cycle. Register-file readback of r9 returns the later-granted data.
- r0 write: src0 to r0, src1 to r3, src2 to r4 → all three ready; we1=1/r3, we2=1/r4; no write to r0 occurs.
- hold: all three valid with hold=1 for 2 cycles → ready=0, we1=we2=0, rr_ptr frozen. Releasing hold resumes from the same priority.
- Saturation: force 2^CNT_W+3 collision cycles → conflict_cnt holds 0xFFFF.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Writeback scheduler: maps three writeback sources onto the register file's
// two write ports with round-robin priority and same-register collision avoidance.
module regfile_wb_arbiter #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int CNT_W  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                hold,
  input  logic [2:0]          src_valid,
  input  logic [3*REG_W-1:0]  src_reg,
  input  logic [3*DATA_W-1:0] src_data,
  output logic [2:0]          src_ready,
  output logic                we1,
  output logic [REG_W-1:0]    writeRegister1,
  output logic [DATA_W-1:0]   writeData1,
  output logic                we2,
  output logic [REG_W-1:0]    writeRegister2,
  output logic [DATA_W-1:0]   writeData2,
  output logic [CNT_W-1:0]    conflict_cnt
);

  logic [1:0]        rr_ptr_q, rr_ptr_d;
  logic              we1_q, we1_d, we2_q, we2_d;
  logic [REG_W-1:0]  wreg1_q, wreg1_d, wreg2_q, wreg2_d;
  logic [DATA_W-1:0] wdata1_q, wdata1_d, wdata2_q, wdata2_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [REG_W-1:0]  reqReg  [3];
  logic [DATA_W-1:0] reqData [3];
  logic [2:0]        sum;
  logic [1:0]        idx;
  logic [1:0]        lastSrc;
  logic              collide;

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      reqReg[i]  = src_reg[i*REG_W +: REG_W];
      reqData[i] = src_data[i*DATA_W +: DATA_W];
    end
  end

  // Visit sources in priority order; port 1 fills first, r0 writes are acked but dropped.
  always_comb begin
    src_ready = '0;
    we1_d     = 1'b0;
    we2_d     = 1'b0;
    wreg1_d   = wreg1_q;
    wreg2_d   = wreg2_q;
    wdata1_d  = wdata1_q;
    wdata2_d  = wdata2_q;
    lastSrc   = rr_ptr_q;
    collide   = 1'b0;
    sum       = '0;
    idx       = '0;
    for (int k = 0; k < 3; k++) begin
      sum = {1'b0, rr_ptr_q} + 3'(k);
      if (sum >= 3'd3) sum = sum - 3'd3;
      idx = sum[1:0];
      if (!hold && src_valid[idx]) begin
        if (reqReg[idx] == '0) begin
          src_ready[idx] = 1'b1;
        end else if ((we1_d && reqReg[idx] == wreg1_d) ||
                     (we2_d && reqReg[idx] == wreg2_d)) begin
          collide = 1'b1;
        end else if (!we1_d) begin
          we1_d          = 1'b1;
          wreg1_d        = reqReg[idx];
          wdata1_d       = reqData[idx];
          src_ready[idx] = 1'b1;
          lastSrc        = idx;
        end else if (!we2_d) begin
          we2_d          = 1'b1;
          wreg2_d        = reqReg[idx];
          wdata2_d       = reqData[idx];
          src_ready[idx] = 1'b1;
          lastSrc        = idx;
        end
      end
    end

    rr_ptr_d = rr_ptr_q;
    if (we1_d) rr_ptr_d = (lastSrc == 2'd2) ? 2'd0 : lastSrc + 2'd1;

    cnt_d = cnt_q;
    if (collide && cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr_q <= '0;
      we1_q    <= 1'b0;
      we2_q    <= 1'b0;
      wreg1_q  <= '0;
      wreg2_q  <= '0;
      wdata1_q <= '0;
      wdata2_q <= '0;
      cnt_q    <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      we1_q    <= we1_d;
      we2_q    <= we2_d;
      wreg1_q  <= wreg1_d;
      wreg2_q  <= wreg2_d;
      wdata1_q <= wdata1_d;
      wdata2_q <= wdata2_d;
      cnt_q    <= cnt_d;
    end
  end

  assign we1            = we1_q;
  assign writeRegister1 = wreg1_q;
  assign writeData1     = wdata1_q;
  assign we2            = we2_q;
  assign writeRegister2 = wreg2_q;
  assign writeData2     = wdata2_q;
  assign conflict_cnt   = cnt_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: randomized traffic against a queue-based
// scheduling model, plus directed scenarios with hand-computed expectations.
module tb_regfile_wb_arbiter;
  localparam int DATA_W = 32;
  localparam int REG_W  = 5;
  localparam int CNT_W  = 16;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic                clk;
  logic                rst;
  logic                hold;
  logic [2:0]          src_valid;
  logic [3*REG_W-1:0]  src_reg;
  logic [3*DATA_W-1:0] src_data;
  logic [2:0]          src_ready;
  logic                we1, we2;
  logic [REG_W-1:0]    writeRegister1, writeRegister2;
  logic [DATA_W-1:0]   writeData1, writeData2;
  logic [CNT_W-1:0]    conflict_cnt;

  regfile_wb_arbiter #(.DATA_W(DATA_W), .REG_W(REG_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .hold(hold),
    .src_valid(src_valid), .src_reg(src_reg), .src_data(src_data),
    .src_ready(src_ready),
    .we1(we1), .writeRegister1(writeRegister1), .writeData1(writeData1),
    .we2(we2), .writeRegister2(writeRegister2), .writeData2(writeData2),
    .conflict_cnt(conflict_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int vectors = 0;
  int miscompares = 0;

  logic [2:0]        tValid;
  logic              tHold;
  logic [REG_W-1:0]  tReg  [3];
  logic [DATA_W-1:0] tData [3];

  int                mRr;
  int                mCnt;
  bit                mWe1, mWe2;
  logic [REG_W-1:0]  mReg1, mReg2;
  logic [DATA_W-1:0] mData1, mData2;
  logic [2:0]        eReady;
  int                grants[$];
  bit                eColl;

  logic [DATA_W-1:0] dutRf [32];

  // Register file fed by the DUT's write ports, used for readback checks.
  always @(posedge clk) begin
    if (we1) dutRf[writeRegister1] <= writeData1;
    if (we2) dutRf[writeRegister2] <= writeData2;
  end

  task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    mRr = 0; mCnt = 0;
    mWe1 = 0; mWe2 = 0;
    mReg1 = '0; mReg2 = '0;
    mData1 = '0; mData2 = '0;
  endtask

  // Scheduling rules: walk sources from the priority pointer; r0 is acked for free,
  // a repeat of an already granted register is a collision, otherwise take a port.
  task automatic modelEval();
    logic [REG_W-1:0] used[$];
    bit dup;
    int s;
    eReady = '0;
    eColl = 0;
    grants.delete();
    if (!tHold) begin
      for (int k = 0; k < 3; k++) begin
        s = (mRr + k) % 3;
        if (tValid[s]) begin
          if (tReg[s] == 0) begin
            eReady[s] = 1'b1;
          end else begin
            dup = 0;
            foreach (used[j]) if (used[j] == tReg[s]) dup = 1;
            if (dup) eColl = 1;
            else if (grants.size() < 2) begin
              grants.push_back(s);
              used.push_back(tReg[s]);
              eReady[s] = 1'b1;
            end
          end
        end
      end
    end
  endtask

  task automatic modelCommit();
    mWe1 = (grants.size() >= 1);
    mWe2 = (grants.size() >= 2);
    if (mWe1) begin mReg1 = tReg[grants[0]]; mData1 = tData[grants[0]]; end
    if (mWe2) begin mReg2 = tReg[grants[1]]; mData2 = tData[grants[1]]; end
    if (grants.size() > 0) mRr = (grants[grants.size()-1] + 1) % 3;
    if (eColl && mCnt < CNT_MAX) mCnt++;
  endtask

  task automatic applyStimulus(input logic [2:0] v, input logic h,
                               input logic [REG_W-1:0] r0, input logic [REG_W-1:0] r1,
                               input logic [REG_W-1:0] r2,
                               input logic [DATA_W-1:0] d0, input logic [DATA_W-1:0] d1,
                               input logic [DATA_W-1:0] d2);
    tValid = v; tHold = h;
    tReg[0] = r0; tReg[1] = r1; tReg[2] = r2;
    tData[0] = d0; tData[1] = d1; tData[2] = d2;
    src_valid = v;
    hold = h;
    src_reg = {r2, r1, r0};
    src_data = {d2, d1, d0};
  endtask

  task automatic checkOutput();
    checkVal("src_ready", 64'(src_ready), 64'(eReady));
    checkVal("we1", 64'(we1), 64'(mWe1));
    checkVal("writeRegister1", 64'(writeRegister1), 64'(mReg1));
    checkVal("writeData1", 64'(writeData1), 64'(mData1));
    checkVal("we2", 64'(we2), 64'(mWe2));
    checkVal("writeRegister2", 64'(writeRegister2), 64'(mReg2));
    checkVal("writeData2", 64'(writeData2), 64'(mData2));
    checkVal("conflict_cnt", 64'(conflict_cnt), 64'(mCnt));
  endtask

  task automatic evalAndCheck();
    modelEval();
    @(negedge clk);
    checkOutput();
  endtask

  task automatic advance();
    @(posedge clk);
    modelCommit();
    #1;
  endtask

  task automatic randomCycle();
    logic [REG_W-1:0] r [3];
    for (int i = 0; i < 3; i++)
      r[i] = ($urandom_range(0, 3) == 0) ? REG_W'($urandom_range(0, 31)) : REG_W'($urandom_range(0, 3));
    applyStimulus(3'($urandom_range(0, 7)), ($urandom_range(0, 7) == 0), r[0], r[1], r[2],
                  $urandom, $urandom, $urandom);
    evalAndCheck();
    advance();
  endtask

  initial begin
    for (int i = 0; i < 32; i++) dutRf[i] = '0;
    rst = 1'b0;
    applyStimulus(3'b000, 1'b0, '0, '0, '0, '0, '0, '0);
    modelReset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    for (int n = 0; n < 3000; n++) randomCycle();

    $display("[TB] mid-stream reset");
    applyStimulus(3'b001, 1'b0, 5'd1, 5'd2, 5'd3, 32'hCAFE0001, 32'h0, 32'h0);
    evalAndCheck();
    advance();
    checkVal("we1 before reset", 64'(we1), 64'h1);
    rst = 1'b0;
    #1;
    checkVal("we1 in reset", 64'(we1), 64'h0);
    checkVal("we2 in reset", 64'(we2), 64'h0);
    checkVal("conflict_cnt in reset", 64'(conflict_cnt), 64'h0);
    modelReset();
    applyStimulus(3'b000, 1'b0, '0, '0, '0, '0, '0, '0);
    #1 rst = 1'b1;

    $display("[TB] three requests");
    applyStimulus(3'b111, 1'b0, 5'd5, 5'd10, 5'd7, 32'hAAAAAAAA, 32'h55555555, 32'h12345678);
    evalAndCheck();
    checkVal("three req ready", 64'(src_ready), 64'h3);
    advance();
    applyStimulus(3'b100, 1'b0, 5'd5, 5'd10, 5'd7, 32'hAAAAAAAA, 32'h55555555, 32'h12345678);
    evalAndCheck();
    checkVal("three req ready2", 64'(src_ready), 64'h4);
    checkVal("three req we1", 64'(we1), 64'h1);
    checkVal("three req reg1", 64'(writeRegister1), 64'd5);
    checkVal("three req data1", 64'(writeData1), 64'hAAAAAAAA);
    checkVal("three req we2", 64'(we2), 64'h1);
    checkVal("three req reg2", 64'(writeRegister2), 64'd10);
    checkVal("three req data2", 64'(writeData2), 64'h55555555);
    advance();
    applyStimulus(3'b000, 1'b0, '0, '0, '0, '0, '0, '0);
    evalAndCheck();
    checkVal("src2 we1", 64'(we1), 64'h1);
    checkVal("src2 reg1", 64'(writeRegister1), 64'd7);
    checkVal("src2 data1", 64'(writeData1), 64'h12345678);
    checkVal("src2 we2", 64'(we2), 64'h0);
    advance();

    $display("[TB] collision on r9");
    applyStimulus(3'b101, 1'b0, 5'd9, 5'd0, 5'd9, 32'h9A9A0000, 32'h0, 32'h2B2B2B2B);
    evalAndCheck();
    checkVal("coll ready", 64'(src_ready), 64'h1);
    checkVal("coll cnt before", 64'(conflict_cnt), 64'h0);
    advance();
    applyStimulus(3'b100, 1'b0, 5'd9, 5'd0, 5'd9, 32'h9A9A0000, 32'h0, 32'h2B2B2B2B);
    evalAndCheck();
    checkVal("coll deferred ready", 64'(src_ready), 64'h4);
    checkVal("coll cnt", 64'(conflict_cnt), 64'h1);
    checkVal("coll data1 first", 64'(writeData1), 64'h9A9A0000);
    advance();
    applyStimulus(3'b000, 1'b0, '0, '0, '0, '0, '0, '0);
    evalAndCheck();
    checkVal("coll data1 second", 64'(writeData1), 64'h2B2B2B2B);
    advance();
    evalAndCheck();
    checkVal("rf r9 readback", 64'(dutRf[9]), 64'h2B2B2B2B);
    advance();

    $display("[TB] r0 request");
    applyStimulus(3'b111, 1'b0, 5'd0, 5'd3, 5'd4, 32'hDEAD0000, 32'h33333333, 32'h44444444);
    evalAndCheck();
    checkVal("r0 ready", 64'(src_ready), 64'h7);
    advance();
    applyStimulus(3'b000, 1'b0, '0, '0, '0, '0, '0, '0);
    evalAndCheck();
    checkVal("r0 reg1", 64'(writeRegister1), 64'd3);
    checkVal("r0 reg2", 64'(writeRegister2), 64'd4);
    advance();
    evalAndCheck();
    checkVal("rf r0 untouched", 64'(dutRf[0]), 64'h0);
    advance();

    $display("[TB] hold");
    for (int c = 0; c < 2; c++) begin
      applyStimulus(3'b111, 1'b1, 5'd11, 5'd12, 5'd13, 32'h11, 32'h12, 32'h13);
      evalAndCheck();
      checkVal("hold ready", 64'(src_ready), 64'h0);
      advance();
    end
    applyStimulus(3'b111, 1'b0, 5'd11, 5'd12, 5'd13, 32'h11, 32'h12, 32'h13);
    evalAndCheck();
    checkVal("hold we1", 64'(we1), 64'h0);
    checkVal("hold we2", 64'(we2), 64'h0);
    checkVal("release ready", 64'(src_ready), 64'h3);
    advance();

    for (int n = 0; n < 1000; n++) randomCycle();

    $display("[TB] conflict counter saturation");
    for (int n = 0; n < CNT_MAX + 4; n++) begin
      applyStimulus(3'b011, 1'b0, 5'd9, 5'd9, 5'd0, $urandom, $urandom, 32'h0);
      evalAndCheck();
      advance();
    end
    applyStimulus(3'b000, 1'b0, '0, '0, '0, '0, '0, '0);
    evalAndCheck();
    checkVal("cnt saturated", 64'(conflict_cnt), 64'hFFFF);
    advance();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
